// File: rtl/mips_pkg.sv
// Shared definitions for the register file slice: default widths and the
// register-address / register-data types used across the design and bench.
package mips_pkg;

  localparam int DW_DEF      = 32;
  localparam int AW_DEF      = 5;
  localparam int ZERO_R0_DEF = 1;
  localparam int DEPTH_DEF   = 2 ** AW_DEF;

  typedef logic [AW_DEF-1:0] reg_addr_t;
  typedef logic [DW_DEF-1:0] reg_data_t;

  // Number of registers that can ever be pending at once.
  function automatic int max_pending(input int aw, input int zero_r0);
    return (zero_r0 != 0) ? (2 ** aw) - 1 : (2 ** aw);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Bus bundle for the register file: two read ports, one write port,
// the issue strobe for the scoreboard and the pending-register count.
interface regfile_sb_if
  import mips_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) ();

  // read port A
  logic [AW-1:0] ar;
  logic [DW-1:0] a;
  logic          a_busy;
  // read port B
  logic [AW-1:0] br;
  logic [DW-1:0] b;
  logic          b_busy;
  // write port
  logic          rwe;
  logic [AW-1:0] wr;
  logic [DW-1:0] w;
  // issue / scoreboard
  logic          iss_en;
  logic [AW-1:0] iss_r;
  logic [AW:0]   busy_cnt;

  // Pipeline side: drives addresses, writes and issues; receives read data.
  modport master (
    output ar, br, rwe, wr, w, iss_en, iss_r,
    input  a, a_busy, b, b_busy, busy_cnt
  );

  // Register file side.
  modport slave (
    input  ar, br, rwe, wr, w, iss_en, iss_r,
    output a, a_busy, b, b_busy, busy_cnt
  );

endinterface

// File: rtl/regfile_busy.sv
// Scoreboard: one pending bit per register plus an incrementally maintained
// count of pending registers. Also registers the pending flag for both read
// addresses, taken from the post-edge value so it lines up with the bypassed
// read data.
module regfile_busy
  import mips_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int ZERO_R0 = ZERO_R0_DEF
) (
  input  logic          t2,
  input  logic          rst_n,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_r,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_r,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic          a_busy,
  output logic          b_busy,
  output logic [AW:0]   busy_cnt
);

  localparam int DEPTH = 2 ** AW;

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;
  logic [AW:0]      cnt_reg;
  logic [AW:0]      cnt_next;
  logic             a_busy_reg;
  logic             b_busy_reg;

  logic iss_ok;
  logic clr_ok;
  logic set_inc;
  logic clr_dec;

  // r0 never becomes pending when it is hardwired to zero.
  assign iss_ok = iss_en && !((ZERO_R0 != 0) && (iss_r == '0));
  assign clr_ok = clr_en && !((ZERO_R0 != 0) && (clr_r == '0));

  // Issue beats write on the same register: the newer producer keeps it busy.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      assign busy_next[gi] = (iss_ok && (iss_r == AW'(gi))) ||
                             (busy_reg[gi] && !(clr_ok && (clr_r == AW'(gi))));
    end
  endgenerate

  // Count moves only on real bit transitions, so it tracks the popcount.
  assign set_inc  = iss_ok && !busy_reg[iss_r];
  assign clr_dec  = clr_ok && busy_reg[clr_r] && !(iss_ok && (iss_r == clr_r));
  assign cnt_next = cnt_reg + (AW+1)'(set_inc) - (AW+1)'(clr_dec);

  // Scoreboard state, count and per-port pending flags.
  always_ff @(posedge t2 or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg   <= '0;
      cnt_reg    <= '0;
      a_busy_reg <= 1'b0;
      b_busy_reg <= 1'b0;
    end else begin
      busy_reg   <= busy_next;
      cnt_reg    <= cnt_next;
      a_busy_reg <= busy_next[ra];
      b_busy_reg <= busy_next[rb];
    end
  end

  assign a_busy   = a_busy_reg;
  assign b_busy   = b_busy_reg;
  assign busy_cnt = cnt_reg;

endmodule

// File: rtl/regfile_sb.sv
// Two-read / one-write register file with registered reads, write-through
// bypass, optional hardwired-zero r0, and an attached pending-write scoreboard.
module regfile_sb
  import mips_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int ZERO_R0 = ZERO_R0_DEF
) (
  input logic         t2,
  input logic         rst_n,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] regs_reg [DEPTH];
  logic [DW-1:0] a_reg;
  logic [DW-1:0] a_next;
  logic [DW-1:0] b_reg;
  logic [DW-1:0] b_next;
  logic          wr_ok;

  // Writes to a hardwired-zero r0 are simply dropped.
  assign wr_ok = bus.rwe && !((ZERO_R0 != 0) && (bus.wr == '0));

  // Register storage; reset must clear every entry, so this is a flop array.
  always_ff @(posedge t2 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_reg[bus.wr] <= bus.w;
    end
  end

  // Read muxes with same-edge write forwarding and forced-zero r0.
  always_comb begin
    a_next = regs_reg[bus.ar];
    b_next = regs_reg[bus.br];
    if (wr_ok && (bus.wr == bus.ar)) begin
      a_next = bus.w;
    end
    if (wr_ok && (bus.wr == bus.br)) begin
      b_next = bus.w;
    end
    if ((ZERO_R0 != 0) && (bus.ar == '0)) begin
      a_next = '0;
    end
    if ((ZERO_R0 != 0) && (bus.br == '0)) begin
      b_next = '0;
    end
  end

  // Registered read data for both ports.
  always_ff @(posedge t2 or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      a_reg <= a_next;
      b_reg <= b_next;
    end
  end

  assign bus.a = a_reg;
  assign bus.b = b_reg;

  regfile_busy #(
    .AW      (AW),
    .ZERO_R0 (ZERO_R0)
  ) u_busy (
    .t2       (t2),
    .rst_n    (rst_n),
    .iss_en   (bus.iss_en),
    .iss_r    (bus.iss_r),
    .clr_en   (bus.rwe),
    .clr_r    (bus.wr),
    .ra       (bus.ar),
    .rb       (bus.br),
    .a_busy   (bus.a_busy),
    .b_busy   (bus.b_busy),
    .busy_cnt (bus.busy_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed stimulus, a behavioural array model checked
// on every falling edge, and literal expectations for the key scenarios.
module tb_regfile_sb;
  import mips_pkg::*;

  logic t2 = 1'b0;
  logic rst_n = 1'b1;
  logic chk_en = 1'b0;

  int tests = 0;
  int failed = 0;

  always #5 t2 = ~t2;

  regfile_sb_if #(.DW(32), .AW(5)) bus ();

  regfile_sb #(.DW(32), .AW(5), .ZERO_R0(1)) dut (
    .t2    (t2),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural model: architectural register and pending arrays.
  logic [31:0] mregs [32];
  bit          mbusy [32];
  logic [31:0] exp_a, exp_b;
  logic        exp_ab, exp_bb;
  logic [5:0]  exp_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = '0;
      mbusy[i] = 1'b0;
    end
    exp_a = '0; exp_b = '0; exp_ab = 1'b0; exp_bb = 1'b0; exp_cnt = '0;
  endtask

  // Apply the edge's write, then its issue, then read the resulting state.
  task automatic model_step();
    int n;
    if (bus.rwe) begin
      if (bus.wr != 5'd0) mregs[bus.wr] = bus.w;
      mbusy[bus.wr] = 1'b0;
    end
    if (bus.iss_en && bus.iss_r != 5'd0) mbusy[bus.iss_r] = 1'b1;
    exp_a  = mregs[bus.ar];
    exp_b  = mregs[bus.br];
    exp_ab = mbusy[bus.ar];
    exp_bb = mbusy[bus.br];
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(mbusy[i]);
    exp_cnt = 6'(n);
  endtask

  task automatic drive(input logic rwe_i, input reg_addr_t wr_i, input logic [31:0] w_i,
                       input logic iss_i, input reg_addr_t issr_i,
                       input reg_addr_t ar_i, input reg_addr_t br_i);
    bus.rwe = rwe_i; bus.wr = wr_i; bus.w = w_i;
    bus.iss_en = iss_i; bus.iss_r = issr_i;
    bus.ar = ar_i; bus.br = br_i;
  endtask

  task automatic idle(input reg_addr_t ar_i, input reg_addr_t br_i);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ar_i, br_i);
  endtask

  // One clock: model follows the rising edge, return on the falling edge.
  task automatic cyc();
    @(posedge t2);
    if (rst_n) model_step();
    @(negedge t2);
  endtask

  // Compare process: DUT outputs against the model every falling edge.
  always @(negedge t2) begin
    if (chk_en) begin
      check("model_a", 64'(bus.a), 64'(exp_a));
      check("model_b", 64'(bus.b), 64'(exp_b));
      check("model_a_busy", 64'(bus.a_busy), 64'(exp_ab));
      check("model_b_busy", 64'(bus.b_busy), 64'(exp_bb));
      check("model_busy_cnt", 64'(bus.busy_cnt), 64'(exp_cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(5'd0, 5'd0);
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("reset_a", 64'(bus.a), 64'd0);
    check("reset_b", 64'(bus.b), 64'd0);
    check("reset_a_busy", 64'(bus.a_busy), 64'd0);
    check("reset_b_busy", 64'(bus.b_busy), 64'd0);
    check("reset_busy_cnt", 64'(bus.busy_cnt), 64'd0);
    repeat (2) @(negedge t2);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Write r5, read it back next cycle.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0); cyc();
    idle(5'd5, 5'd0); cyc();
    check("r5_readback", 64'(bus.a), 64'hDEADBEEF);

    // Same-edge write and read of r7 on both ports.
    drive(1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 5'd7, 5'd7); cyc();
    check("bypass_a", 64'(bus.a), 64'h00001234);
    check("bypass_b", 64'(bus.b), 64'h00001234);

    // r0 is hardwired: write and issue both ignored.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0); cyc();
    idle(5'd0, 5'd0); cyc();
    check("r0_a", 64'(bus.a), 64'd0);
    check("r0_a_busy", 64'(bus.a_busy), 64'd0);
    check("r0_busy_cnt", 64'(bus.busy_cnt), 64'd0);

    // Scoreboard sequence.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd0); cyc();
    check("iss3_a_busy", 64'(bus.a_busy), 64'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd3, 5'd4); cyc();
    check("iss34_cnt", 64'(bus.busy_cnt), 64'd2);
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd4, 5'd3); cyc();
    check("wr3_cnt", 64'(bus.busy_cnt), 64'd1);
    check("wr3_b_busy", 64'(bus.b_busy), 64'd0);
    check("wr3_b", 64'(bus.b), 64'h33);
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 5'd4, 5'd0); cyc();
    check("iss_wr4_cnt", 64'(bus.busy_cnt), 64'd1);
    check("iss_wr4_a_busy", 64'(bus.a_busy), 64'd1);
    check("iss_wr4_a", 64'(bus.a), 64'h44);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd0); cyc();
    check("reiss4_cnt", 64'(bus.busy_cnt), 64'd1);
    drive(1'b1, 5'd10, 32'hA5A5, 1'b0, 5'd0, 5'd10, 5'd4); cyc();
    check("wr_nonbusy_cnt", 64'(bus.busy_cnt), 64'd1);
    drive(1'b1, 5'd4, 32'h4444, 1'b1, 5'd6, 5'd6, 5'd4); cyc();
    check("net0_cnt", 64'(bus.busy_cnt), 64'd1);
    check("net0_b_busy", 64'(bus.b_busy), 64'd0);
    drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 5'd6, 5'd4); cyc();
    check("clr6_cnt", 64'(bus.busy_cnt), 64'd0);

    // Issue r9 then reset part-way through a cycle with a write in flight.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd5); cyc();
    check("iss9_cnt", 64'(bus.busy_cnt), 64'd1);
    #2;
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd12, 5'd9, 5'd5);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_a", 64'(bus.a), 64'd0);
    check("midrst_b", 64'(bus.b), 64'd0);
    check("midrst_cnt", 64'(bus.busy_cnt), 64'd0);
    @(negedge t2);
    idle(5'd9, 5'd5);
    rst_n = 1'b1;
    cyc();
    check("post_rst_a", 64'(bus.a), 64'd0);
    check("post_rst_a_busy", 64'(bus.a_busy), 64'd0);
    check("post_rst_b", 64'(bus.b), 64'd0);

    // Fill the scoreboard, then drain it with writes.
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(i), 5'(i - 1)); cyc();
    end
    check("all_busy_cnt", 64'(bus.busy_cnt), 64'd31);
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'h01010101 * 32'(i), 1'b0, 5'd0, 5'(i), 5'(32 - i)); cyc();
    end
    check("drain_cnt", 64'(bus.busy_cnt), 64'd0);
    check("drain_a31", 64'(bus.a), 64'h1F1F1F1F);
    idle(5'd17, 5'd17); cyc();
    check("same_addr_a", 64'(bus.a), 64'h11111111);
    check("same_addr_b", 64'(bus.b), 64'h11111111);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DW, default 32, data width of each register.
REQ-002 Parameter AW, default 5, register address width; depth is 2**AW.
REQ-003 Parameter ZERO_R0, default 1, register 0 hardwired to zero when 1.
REQ-004 t2  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ar  input  AW  read address, port A.
REQ-007 a  output  DW  registered read data, port A.
REQ-008 a_busy  output  1  registered pending-write flag for ar.
REQ-009 br  input  AW  read address, port B.
REQ-010 b  output  DW  registered read data, port B.
REQ-011 b_busy  output  1  registered pending-write flag for br.
REQ-012 rwe  input  1  write enable.
REQ-013 wr  input  AW  write address.
REQ-014 w  input  DW  write data.
REQ-015 iss_en  input  1  issue strobe; marks iss_r as pending producer.
REQ-016 iss_r  input  AW  destination register being issued.
REQ-017 busy_cnt  output  AW+1  registered count of pending registers.

Function
REQ-018 Write: on rising edge with rwe=1, regs[wr] <= w; single write port.
REQ-019 Read latency 1 cycle: a/b at edge N+1 reflect ar/br sampled at edge N.
REQ-020 Write-through bypass: same-edge rwe=1 and wr==ar returns w on a (likewise b); no stale data.
REQ-021 ZERO_R0=1: writes to r0 dropped, reads of r0 return 0, iss_en to r0 ignored, a_busy/b_busy for r0 always 0.
REQ-022 Scoreboard: one busy bit per register; iss_en sets busy[iss_r]; rwe clears busy[wr].
REQ-023 Same-edge iss_en and rwe to same register: busy remains 1 (new producer wins); data still written.
REQ-024 Issue to already-busy register: bit stays 1, busy_cnt unchanged.
REQ-025 Write to non-busy register: data written, busy unchanged, busy_cnt unchanged.
REQ-026 a_busy/b_busy report busy next-state of the same edge (consistent with bypass).
REQ-027 busy_cnt updated incrementally: +1 on set of clear bit, -1 on clear of set bit not re-set, net 0 when both on distinct regs; equals popcount of busy bits at all times.
REQ-028 busy_cnt saturation impossible by width; max value 2**AW (2**AW-1 when ZERO_R0=1).
REQ-029 Both read ports independent; ar==br legal, returns identical data.

Reset
REQ-030 rst_n=0 asynchronously clears all registers, busy bits, a, b, a_busy, b_busy, busy_cnt to 0.
REQ-031 Reset mid-operation discards in-flight write and issue of that edge; first valid write at first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package mips_pkg holds DW/AW defaults and the register-address type.
REQ-033 Scoreboard (busy bits + busy_cnt) in sub-module regfile_busy; storage, bypass, read registers in regfile_sb.

Verification
REQ-034 Reset, then write r5=0xDEADBEEF, read ar=5 next cycle -> a=0xDEADBEEF one cycle later.
REQ-035 Same cycle rwe=1 wr=7 w=0x1234, ar=7 -> a=0x00001234 next edge (bypass).
REQ-036 ZERO_R0=1: write r0=0xFFFFFFFF, iss_en iss_r=0, read ar=0 -> a=0, a_busy=0, busy_cnt=0.
REQ-037 iss r3, iss r4 -> busy_cnt=2; write r3 -> busy_cnt=1, b_busy(br=3)=0; same-edge iss r4 + write r4 -> busy_cnt=1, busy[4]=1.
REQ-038 Issue r9, then rst_n low mid-cycle -> a, b, busy_cnt=0 immediately; read r9 after reset -> a=0, a_busy=0.
REQ-039 Issue all 31 nonzero registers -> busy_cnt=31; write all back -> busy_cnt=0.
